// File: rtl/packet_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// packet_ctrl_pkg
// Shared definitions for the packet control AXI-Lite master:
//   - state_e     : controller state encoding
//   - LEN_OFFSET  : length register offset from the target base address
//   - START_OFFSET: start register offset from the target base address
//   - OKAY        : AXI response code for a successful access
//   - resp_is_err : helper that classifies an AXI response
// ---------------------------------------------------------------------------
package packet_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_LEN  = 3'd1,
        WR_CLR  = 3'd2,
        HOLD    = 3'd3,
        WR_SET  = 3'd4,
        RD_REQ  = 3'd5,
        RD_WAIT = 3'd6,
        FIN     = 3'd7
    } state_e;

    localparam logic [31:0] LEN_OFFSET   = 32'h0000_0000;
    localparam logic [31:0] START_OFFSET = 32'h0000_0004;
    localparam logic [1:0]  OKAY         = 2'b00;

    // Any response other than OKAY (SLVERR, DECERR, EXOKAY) fails the sequence.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != OKAY);
    endfunction

endpackage

// File: rtl/axil_wr_single.sv
// ---------------------------------------------------------------------------
// axil_wr_single
// One-shot AXI-Lite write engine. A one-cycle start_i pulse captures addr_i
// and data_i and raises AWVALID and WVALID together (WSTRB all ones). Each
// valid drops on its own handshake; once both handshakes are complete BREADY
// is held until BVALID. done_o pulses for one cycle after the B handshake,
// with resp_o holding the captured BRESP.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               launch one write (only while no write is in flight)
//   addr_i, data_i        write address / data
//   done_o, resp_o        completion pulse / write response
//   m_axi_aw*, m_axi_w*, m_axi_b*  AXI-Lite write channels
// ---------------------------------------------------------------------------
module axil_wr_single
    import packet_ctrl_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   data_i,
    output logic            done_o,
    output logic [1:0]      resp_o,
    output logic [AW-1:0]   m_axi_awaddr,
    output logic            m_axi_awvalid,
    input  logic            m_axi_awready,
    output logic [DW-1:0]   m_axi_wdata,
    output logic [DW/8-1:0] m_axi_wstrb,
    output logic            m_axi_wvalid,
    input  logic            m_axi_wready,
    input  logic [1:0]      m_axi_bresp,
    input  logic            m_axi_bvalid,
    output logic            m_axi_bready
);

    localparam logic [DW/8-1:0] STRB_ALL = {(DW/8){1'b1}};

    logic            awvalid_q, awvalid_d;
    logic            wvalid_q,  wvalid_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q,  w_done_d;
    logic            bready_q,  bready_d;
    logic            done_q,    done_d;
    logic [1:0]      resp_q,    resp_d;
    logic [AW-1:0]   awaddr_q,  awaddr_d;
    logic [DW-1:0]   wdata_q,   wdata_d;
    logic [DW/8-1:0] wstrb_q,   wstrb_d;
    logic            aw_hs_s, w_hs_s, b_hs_s;

    assign aw_hs_s = awvalid_q & m_axi_awready;
    assign w_hs_s  = wvalid_q  & m_axi_wready;
    assign b_hs_s  = bready_q  & m_axi_bvalid;

    // Next-state for the write channels; address/data only change on start.
    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        done_d    = 1'b0;
        resp_d    = resp_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (start_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            bready_d  = 1'b0;
            resp_d    = OKAY;
            awaddr_d  = addr_i;
            wdata_d   = data_i;
            wstrb_d   = STRB_ALL;
        end else if (b_hs_s) begin
            bready_d  = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            done_d    = 1'b1;
            resp_d    = m_axi_bresp;
        end else begin
            // AW and W complete independently; B is only accepted after both.
            awvalid_d = awvalid_q & ~m_axi_awready;
            wvalid_d  = wvalid_q  & ~m_axi_wready;
            aw_done_d = aw_done_q | aw_hs_s;
            w_done_d  = w_done_q  | w_hs_s;
            bready_d  = aw_done_d & w_done_d;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= OKAY;
            awaddr_q  <= {AW{1'b0}};
            wdata_q   <= {DW{1'b0}};
            wstrb_q   <= {(DW/8){1'b0}};
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign done_o        = done_q;
    assign resp_o        = resp_q;

endmodule

// File: rtl/packet_ctrl_axil_master.sv
// ---------------------------------------------------------------------------
// packet_ctrl_axil_master
// Accepts a packet-length command and programs a target over AXI-Lite:
// length -> BASE+0x0, start=0 -> BASE+0x4, START_LOW_CYCLES idle cycles,
// start=1 -> BASE+0x4, then a one-cycle done pulse (err flags failure).
// A zero length is rejected without any bus access.
// Optional macro PACKET_CTRL_READBACK_EN: read back the length register after
// writing it and abort with err=1 when the value or response is wrong.
// Ports:
//   m_axi_aclk, m_axi_areset   clock, synchronous active-high reset
//   cmd_valid/ready, cmd_length command handshake and length (beats)
//   busy, done, err             status
//   m_axi_aw*/w*/b*/ar*/r*      AXI-Lite master channels
// ---------------------------------------------------------------------------
module packet_ctrl_axil_master
    import packet_ctrl_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int BASE_ADDR          = 0,
    parameter int START_LOW_CYCLES   = 8
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_areset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [31:0]                     cmd_length,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] LEN_ADDR   = AW'(32'(BASE_ADDR) + LEN_OFFSET);
    localparam logic [AW-1:0] START_ADDR = AW'(32'(BASE_ADDR) + START_OFFSET);
    // HOLD lasts HOLD_LAST+1 cycles; a zero setting still passes through once.
    localparam logic [31:0]   HOLD_LAST  =
        (START_LOW_CYCLES > 0) ? 32'(START_LOW_CYCLES - 1) : 32'h0;

    state_e        state_q, state_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   hold_cnt_q, hold_cnt_d;
    logic          busy_q, done_q, err_q, cmd_ready_q;
    logic          fin_err_d;
    logic          wr_start_s;
    logic [AW-1:0] wr_addr_s;
    logic [DW-1:0] wr_data_s;
    logic          wr_done_s;
    logic [1:0]    wr_resp_s;

    // Sequencer next-state; write starts are issued on entry to a write state.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        hold_cnt_d = hold_cnt_q;
        fin_err_d  = 1'b0;
        wr_start_s = 1'b0;
        wr_addr_s  = LEN_ADDR;
        wr_data_s  = DW'(len_q);
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    len_d   = cmd_length;
                    state_d = WR_LEN;
                    if (cmd_length != 32'h0) begin
                        wr_start_s = 1'b1;
                        wr_addr_s  = LEN_ADDR;
                        wr_data_s  = DW'(cmd_length);
                    end else begin
                        wr_start_s = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_LEN: begin
                if (len_q == 32'h0) begin
                    state_d   = FIN;
                    fin_err_d = 1'b1;
                end else if (wr_done_s) begin
                    if (resp_is_err(wr_resp_s)) begin
                        state_d   = FIN;
                        fin_err_d = 1'b1;
                    end else begin
`ifdef PACKET_CTRL_READBACK_EN
                        state_d    = RD_REQ;
`else
                        state_d    = WR_CLR;
                        wr_start_s = 1'b1;
                        wr_addr_s  = START_ADDR;
                        wr_data_s  = {DW{1'b0}};
`endif
                    end
                end else begin
                    state_d = WR_LEN;
                end
            end
`ifdef PACKET_CTRL_READBACK_EN
            RD_REQ: begin
                if (m_axi_arvalid && m_axi_arready) begin
                    state_d = RD_WAIT;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (m_axi_rvalid && m_axi_rready) begin
                    if (resp_is_err(m_axi_rresp) || (m_axi_rdata != DW'(len_q))) begin
                        state_d   = FIN;
                        fin_err_d = 1'b1;
                    end else begin
                        state_d    = WR_CLR;
                        wr_start_s = 1'b1;
                        wr_addr_s  = START_ADDR;
                        wr_data_s  = {DW{1'b0}};
                    end
                end else begin
                    state_d = RD_WAIT;
                end
            end
`endif
            WR_CLR: begin
                if (wr_done_s) begin
                    if (resp_is_err(wr_resp_s)) begin
                        state_d   = FIN;
                        fin_err_d = 1'b1;
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = 32'h0;
                    end
                end else begin
                    state_d = WR_CLR;
                end
            end
            HOLD: begin
                if (hold_cnt_q >= HOLD_LAST) begin
                    state_d    = WR_SET;
                    wr_start_s = 1'b1;
                    wr_addr_s  = START_ADDR;
                    wr_data_s  = DW'(32'h1);
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'h1;
                end
            end
            WR_SET: begin
                if (wr_done_s) begin
                    state_d   = FIN;
                    fin_err_d = resp_is_err(wr_resp_s);
                end else begin
                    state_d = WR_SET;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                // Unreachable encodings (and RD_* without readback) recover to IDLE.
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; status outputs are registered from the next state.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q     <= IDLE;
            len_q       <= 32'h0;
            hold_cnt_q  <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hold_cnt_q  <= hold_cnt_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == FIN);
            err_q       <= fin_err_d;
            cmd_ready_q <= (state_d == IDLE);
        end
    end

`ifdef PACKET_CTRL_READBACK_EN
    logic          arvalid_q, rready_q;
    logic [AW-1:0] araddr_q;

    // Read channel: ARVALID spans RD_REQ, RREADY spans RD_WAIT.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= {AW{1'b0}};
        end else begin
            arvalid_q <= (state_d == RD_REQ);
            rready_q  <= (state_d == RD_WAIT);
            araddr_q  <= (state_d == RD_REQ) ? LEN_ADDR : araddr_q;
        end
    end

    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign m_axi_araddr  = araddr_q;
`else
    logic unused_rd_s;
    assign unused_rd_s   = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b0;
    assign m_axi_araddr  = {AW{1'b0}};
`endif

    axil_wr_single #(
        .AW (AW),
        .DW (DW)
    ) u_wr (
        .clk_i         (m_axi_aclk),
        .rst_i         (m_axi_areset),
        .start_i       (wr_start_s),
        .addr_i        (wr_addr_s),
        .data_i        (wr_data_s),
        .done_o        (wr_done_s),
        .resp_o        (wr_resp_s),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_packet_ctrl_axil_master.sv
// ---------------------------------------------------------------------------
// tb_packet_ctrl_axil_master
// Directed bench with a reactive AXI-Lite slave. Expected writes and the
// expected err flag are queued when a command is driven and compared as the
// slave observes each completed write and as done pulses.
// ---------------------------------------------------------------------------
module tb_packet_ctrl_axil_master;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          m_axi_aclk = 1'b0;
    logic          m_axi_areset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_length;
    logic          busy, done, err;
    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid, m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wvalid, m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid, m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid, m_axi_rready;

    always #5 m_axi_aclk = ~m_axi_aclk;

    packet_ctrl_axil_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .BASE_ADDR          (0),
        .START_LOW_CYCLES   (8)
    ) dut (
        .m_axi_aclk    (m_axi_aclk),
        .m_axi_areset  (m_axi_areset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_length    (cmd_length),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Scoreboard: expected {addr, data} per write and expected err per command.
    logic [63:0] exp_wr_q[$];
    logic        exp_err_q[$];

    // Slave configuration and observation counters.
    int          aw_dly = 0, w_dly = 0, err_wr_idx = -1;
    logic        rd_override_en = 1'b0;
    logic [31:0] rd_override_val = 32'h0;
    logic [31:0] reg0 = 32'h0;
    int          aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, wr_cnt = 0;
    int          extra_wr = 0, proto_err = 0, cyc = 0;
    int          b2_cyc = -1, aw3_cyc = -1, aw3_base = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reactive slave: decides ready/valid at each negedge, so a handshake seen
    // here happens at the following posedge.
    task automatic slave_run();
        logic          aw_got = 1'b0, w_got = 1'b0;
        logic [AW-1:0] c_addr = '0;
        logic [31:0]   c_data = 32'h0;
        logic [3:0]    c_strb = 4'h0;
        int            aw_age = 0, w_age = 0;
        logic          b_pend = 1'b0, b_hs_pend = 1'b0, r_pend = 1'b0, r_hs_pend = 1'b0;
        logic          p_awv = 1'b0, p_awhs = 1'b0, p_wv = 1'b0, p_whs = 1'b0;
        logic [AW-1:0] p_awaddr = '0;
        logic [31:0]   p_wdata = 32'h0;
        logic          aw_hs, w_hs;
        logic [63:0]   e;
        forever begin
            @(negedge m_axi_aclk);
            cyc++;
            if (m_axi_areset) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
                aw_got = 1'b0; w_got = 1'b0; aw_age = 0; w_age = 0;
                b_pend = 1'b0; b_hs_pend = 1'b0; r_pend = 1'b0; r_hs_pend = 1'b0;
                p_awv = 1'b0; p_wv = 1'b0; p_awhs = 1'b0; p_whs = 1'b0;
                continue;
            end
            if (p_awv && !p_awhs && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) proto_err++;
            if (p_wv && !p_whs && (!m_axi_wvalid || m_axi_wdata != p_wdata)) proto_err++;
            if (m_axi_awvalid) begin
                if (aw_age == 0 && wr_cnt == aw3_base + 2 && aw3_cyc < 0) aw3_cyc = cyc;
                m_axi_awready = (aw_age >= aw_dly);
                aw_age++;
            end else begin
                m_axi_awready = 1'b0;
                aw_age = 0;
            end
            if (m_axi_wvalid) begin
                m_axi_wready = (w_age >= w_dly);
                w_age++;
            end else begin
                m_axi_wready = 1'b0;
                w_age = 0;
            end
            aw_hs = m_axi_awvalid && m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;
            if (aw_hs) begin aw_hs_cnt++; aw_got = 1'b1; c_addr = m_axi_awaddr; end
            if (w_hs)  begin w_hs_cnt++;  w_got = 1'b1; c_data = m_axi_wdata; c_strb = m_axi_wstrb; end
            p_awv = m_axi_awvalid; p_awhs = aw_hs; p_awaddr = m_axi_awaddr;
            p_wv  = m_axi_wvalid;  p_whs  = w_hs;  p_wdata  = m_axi_wdata;
            if (aw_got && w_got) begin
                if (exp_wr_q.size() > 0) begin
                    e = exp_wr_q.pop_front();
                    check("write_addr_data", {28'h0, c_addr, c_data}, e);
                    check("write_strb", c_strb, 4'hF);
                end else begin
                    extra_wr++;
                end
                if (c_addr == 4'h0) reg0 = c_data;
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
            end
            if (b_hs_pend) begin
                m_axi_bvalid = 1'b0; b_hs_pend = 1'b0;
            end else if (b_pend && !m_axi_bvalid) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (wr_cnt == err_wr_idx) ? 2'b10 : 2'b00;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_hs_pend = 1'b1; b_pend = 1'b0; wr_cnt++;
                if (wr_cnt == aw3_base + 2) b2_cyc = cyc;
            end
            if (r_hs_pend) begin
                m_axi_rvalid = 1'b0; r_hs_pend = 1'b0;
            end else if (r_pend && !m_axi_rvalid) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = rd_override_en ? rd_override_val : reg0;
                m_axi_rresp  = 2'b00;
            end
            if (m_axi_rvalid && m_axi_rready) begin r_hs_pend = 1'b1; r_pend = 1'b0; end
            m_axi_arready = m_axi_arvalid;
            if (m_axi_arvalid && m_axi_arready) begin ar_hs_cnt++; r_pend = 1'b1; end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_cmd(input logic [31:0] len, output time t_acc);
        logic ok = 1'b0;
        t_acc = 0;
        cmd_valid  = 1'b1;
        cmd_length = len;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin ok = 1'b1; t_acc = $time; break; end
            @(negedge m_axi_aclk);
        end
        if (!ok) check("cmd_ready_timeout", cmd_ready, 1'b1);
        @(negedge m_axi_aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output time t_done);
        logic got = 1'b0;
        logic e;
        int   busy_low = 0;
        t_done = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy) busy_low++;
            if (done) begin got = 1'b1; t_done = $time; break; end
            @(negedge m_axi_aclk);
        end
        if (!got) begin
            check("done_timeout", done, 1'b1);
        end else begin
            e = 1'bx;
            if (exp_err_q.size() > 0) e = exp_err_q.pop_front();
            check("err_at_done", err, e);
            check("busy_held_to_done", busy_low, 0);
            @(negedge m_axi_aclk);
            check("done_single_cycle", {done, err}, 2'b00);
            check("idle_after_done", {busy, cmd_ready}, 2'b01);
        end
    endtask

    task automatic push_full(input logic [31:0] len);
        exp_wr_q.push_back({28'h0, 4'h0, len});
        exp_wr_q.push_back({28'h0, 4'h4, 32'h0});
        exp_wr_q.push_back({28'h0, 4'h4, 32'h1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t_acc, t_done;
        int  aw0, w0, wr0, ar0, rb_ar;
        logic seen_done;
`ifdef PACKET_CTRL_READBACK_EN
        rb_ar = 1;
`else
        rb_ar = 0;
`endif
        m_axi_areset = 1'b1; cmd_valid = 1'b0; cmd_length = 32'h0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;
        fork slave_run(); join_none

        // Reset values
        repeat (3) @(negedge m_axi_aclk);
        check("reset_ctrl", {cmd_ready, busy, done, err, m_axi_awvalid, m_axi_wvalid,
                             m_axi_bready, m_axi_arvalid, m_axi_rready}, 9'h0);
        check("reset_addr_data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}, 44'h0);
        m_axi_areset = 1'b0;
        @(negedge m_axi_aclk);
        @(negedge m_axi_aclk);
        check("ready_after_reset", cmd_ready, 1'b1);

        // Nominal sequence, always-ready slave
        aw0 = aw_hs_cnt; wr0 = wr_cnt; ar0 = ar_hs_cnt;
        aw3_base = wr_cnt; b2_cyc = -1; aw3_cyc = -1;
        push_full(32'd16); exp_err_q.push_back(1'b0);
        send_cmd(32'd16, t_acc);
        wait_done(300, t_done);
        check("nominal_writes", wr_cnt - wr0, 3);
        check("nominal_aw_count", aw_hs_cnt - aw0, 3);
        check("nominal_ar_count", ar_hs_cnt - ar0, rb_ar);
        check("hold_gap_ge8", (b2_cyc >= 0) && (aw3_cyc - b2_cyc - 1 >= 8), 1'b1);

        // WREADY three cycles before AWREADY
        aw_dly = 3; w_dly = 0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; wr0 = wr_cnt;
        push_full(32'd16); exp_err_q.push_back(1'b0);
        send_cmd(32'd16, t_acc);
        wait_done(300, t_done);
        check("wfirst_aw_count", aw_hs_cnt - aw0, 3);
        check("wfirst_w_count", w_hs_cnt - w0, 3);
        check("wfirst_writes", wr_cnt - wr0, 3);

        // AWREADY before WREADY, odd length
        aw_dly = 0; w_dly = 2;
        wr0 = wr_cnt;
        push_full(32'hA5A5_0007); exp_err_q.push_back(1'b0);
        send_cmd(32'hA5A5_0007, t_acc);
        wait_done(300, t_done);
        check("awfirst_writes", wr_cnt - wr0, 3);
        w_dly = 0;

        // SLVERR on the start-clear write
        aw0 = aw_hs_cnt; wr0 = wr_cnt;
        err_wr_idx = wr_cnt + 1;
        exp_wr_q.push_back({28'h0, 4'h0, 32'd16});
        exp_wr_q.push_back({28'h0, 4'h4, 32'h0});
        exp_err_q.push_back(1'b1);
        send_cmd(32'd16, t_acc);
        wait_done(300, t_done);
        repeat (20) @(negedge m_axi_aclk);
        check("bresp_err_writes", wr_cnt - wr0, 2);
        check("bresp_err_aw_count", aw_hs_cnt - aw0, 2);
        err_wr_idx = -1;

        // Zero length is rejected without bus activity
        aw0 = aw_hs_cnt; ar0 = ar_hs_cnt;
        exp_err_q.push_back(1'b1);
        send_cmd(32'd0, t_acc);
        wait_done(50, t_done);
        check("len0_done_latency_ns", t_done - t_acc, 64'd20);
        check("len0_no_bus", {aw_hs_cnt - aw0, ar_hs_cnt - ar0}, 64'h0);

        // Reset during HOLD, then a full sequence
        wr0 = wr_cnt; aw0 = aw_hs_cnt; seen_done = 1'b0;
        push_full(32'd16); exp_err_q.push_back(1'b0);
        send_cmd(32'd16, t_acc);
        for (int i = 0; i < 300 && wr_cnt < wr0 + 2; i++) begin
            @(negedge m_axi_aclk);
            seen_done |= done;
        end
        repeat (3) begin @(negedge m_axi_aclk); seen_done |= done; end
        m_axi_areset = 1'b1;
        @(negedge m_axi_aclk);
        seen_done |= done;
        check("hold_reset_ctrl", {cmd_ready, busy, done, err, m_axi_awvalid, m_axi_wvalid,
                                  m_axi_bready, m_axi_arvalid, m_axi_rready}, 9'h0);
        check("hold_reset_addr_data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}, 44'h0);
        m_axi_areset = 1'b0;
        repeat (3) begin @(negedge m_axi_aclk); seen_done |= done; end
        check("hold_reset_no_done", seen_done, 1'b0);
        check("hold_reset_pending_writes", exp_wr_q.size(), 1);
        check("hold_reset_aw_count", aw_hs_cnt - aw0, 2);
        exp_wr_q.delete();
        exp_err_q.delete();
        wr0 = wr_cnt;
        push_full(32'd16); exp_err_q.push_back(1'b0);
        send_cmd(32'd16, t_acc);
        wait_done(300, t_done);
        check("after_reset_writes", wr_cnt - wr0, 3);

`ifdef PACKET_CTRL_READBACK_EN
        // Readback mismatch aborts before the start writes
        wr0 = wr_cnt; ar0 = ar_hs_cnt;
        rd_override_en = 1'b1; rd_override_val = 32'd15;
        exp_wr_q.push_back({28'h0, 4'h0, 32'd16});
        exp_err_q.push_back(1'b1);
        send_cmd(32'd16, t_acc);
        wait_done(300, t_done);
        repeat (10) @(negedge m_axi_aclk);
        check("readback_writes", wr_cnt - wr0, 1);
        check("readback_ar_count", ar_hs_cnt - ar0, 1);
        rd_override_en = 1'b0;
`else
        check("no_read_activity", ar_hs_cnt, 0);
`endif

        check("no_extra_writes", extra_wr, 0);
        check("valid_stability", proto_err, 0);
        check("scoreboard_empty", {exp_wr_q.size(), exp_err_q.size()}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
